// File: rtl/spike_rate_encoder_if.sv
// spike_rate_encoder_if: frame handshake and spike-train outputs of the rate encoder
//   in_valid/in_ready/in_count : frame request handshake (master -> encoder)
//   spike, frame_active, frame_done, clipped, emitted_count : encoder status (encoder -> master)
interface spike_rate_encoder_if #(
    parameter int COUNT_WIDTH = 16
);
    logic                   in_valid;
    logic                   in_ready;
    logic [COUNT_WIDTH-1:0] in_count;
    logic                   spike;
    logic                   frame_active;
    logic                   frame_done;
    logic                   clipped;
    logic [COUNT_WIDTH-1:0] emitted_count;

    modport master (
        output in_valid, in_count,
        input  in_ready, spike, frame_active, frame_done, clipped, emitted_count
    );

    modport slave (
        input  in_valid, in_count,
        output in_ready, spike, frame_active, frame_done, clipped, emitted_count
    );
endinterface

// File: rtl/spike_rate_encoder.sv
// spike_rate_encoder: spreads a spike count evenly over a WINDOW_LEN-slot frame (Bresenham)
//   clk, rst : clock and synchronous active-high reset
//   bus      : slave side of spike_rate_encoder_if (count handshake in, spike train and status out)
module spike_rate_encoder #(
    parameter int COUNT_WIDTH = 16,
    parameter int WINDOW_LEN  = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    spike_rate_encoder_if.slave   bus
);
    localparam int AW = $clog2(WINDOW_LEN) + 1;
    localparam int SW = $clog2(WINDOW_LEN);
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]             r_state;
    logic [SW-1:0]          r_slot;
    logic [AW-1:0]          r_acc;
    logic [AW-1:0]          r_target;
    logic                   r_spike;
    logic                   r_done;
    logic                   r_clipped;
    logic [COUNT_WIDTH-1:0] r_emitted;
    logic                   w_clip;
    logic [AW-1:0]          w_sum;
    logic                   w_fire;
    logic                   w_last;

    // acc < WINDOW_LEN and target <= WINDOW_LEN, so the sum always fits in AW bits
    assign w_clip = bus.in_count > COUNT_WIDTH'(WINDOW_LEN);
    assign w_sum  = r_acc + r_target;
    assign w_fire = w_sum >= AW'(WINDOW_LEN);
    assign w_last = r_slot == SW'(WINDOW_LEN - 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_slot    <= '0;
            r_acc     <= '0;
            r_target  <= '0;
            r_spike   <= 1'b0;
            r_done    <= 1'b0;
            r_clipped <= 1'b0;
            r_emitted <= '0;
        end else if (r_state == S_IDLE) begin
            r_spike <= 1'b0;
            r_done  <= 1'b0;
            if (bus.in_valid) begin
                r_state   <= S_RUN;
                r_target  <= w_clip ? AW'(WINDOW_LEN) : AW'(bus.in_count);
                r_clipped <= w_clip;
                r_slot    <= '0;
                r_acc     <= '0;
                r_emitted <= '0;
            end
        end else begin
            r_spike   <= w_fire;
            r_acc     <= w_fire ? w_sum - AW'(WINDOW_LEN) : w_sum;
            r_emitted <= r_emitted + COUNT_WIDTH'(w_fire);
            r_slot    <= r_slot + SW'(1);
            r_done    <= w_last;
            r_state   <= w_last ? S_IDLE : S_RUN;
        end
    end

    assign bus.in_ready      = (r_state == S_IDLE) && !rst;
    assign bus.spike         = r_spike;
    assign bus.frame_active  = r_state == S_RUN;
    assign bus.frame_done    = r_done;
    assign bus.clipped       = r_clipped;
    assign bus.emitted_count = r_emitted;
endmodule

// File: tb/tb_spike_rate_encoder.sv
// tb_spike_rate_encoder: directed and table-driven checks of spike_rate_encoder with WINDOW_LEN = 8
module tb_spike_rate_encoder;
    localparam int W = 8;

    typedef struct {
        logic [15:0] count;
        logic [7:0]  mask;
        logic [15:0] emitted;
        logic        clipped;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_err = 0;
    vec_t vecs[10];

    always #5 clk = ~clk;

    spike_rate_encoder_if #(.COUNT_WIDTH(16)) bus ();

    spike_rate_encoder #(.COUNT_WIDTH(16), .WINDOW_LEN(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_ready();
        int t = 0;
        while (bus.in_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (bus.in_ready !== 1'b1) chk("ready_timeout", 32'(bus.in_ready), 1);
    endtask

    // Accepts one frame and records spike/done/ready/active for cycles 0..8 (bit = cycle)
    task automatic run_frame(input logic [15:0] cnt, output logic [8:0] sm, output logic [8:0] dm,
                             output logic [8:0] rm, output logic [8:0] am);
        wait_ready();
        bus.in_valid = 1'b1;
        bus.in_count = cnt;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        for (int c = 0; c <= W; c++) begin
            @(negedge clk);
            sm[c] = bus.spike;
            dm[c] = bus.frame_done;
            rm[c] = bus.in_ready;
            am[c] = bus.frame_active;
            bus.in_count = 16'($urandom);
        end
    endtask

    task automatic check_frame(input vec_t v);
        logic [8:0] sm, dm, rm, am;
        run_frame(v.count, sm, dm, rm, am);
        chk($sformatf("spike_mask[%0d]", v.count), 32'(sm), 32'({v.mask, 1'b0}));
        chk($sformatf("done_mask[%0d]", v.count), 32'(dm), 32'h100);
        chk($sformatf("ready_mask[%0d]", v.count), 32'(rm), 32'h100);
        chk($sformatf("active_mask[%0d]", v.count), 32'(am), 32'h0FF);
        chk($sformatf("emitted[%0d]", v.count), 32'(bus.emitted_count), 32'(v.emitted));
        chk($sformatf("clipped[%0d]", v.count), 32'(bus.clipped), 32'(v.clipped));
        @(negedge clk);
        chk($sformatf("gap_quiet[%0d]", v.count), 32'({bus.spike, bus.frame_done}), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [8:0]  sm, dm, rm, am;
        logic [17:0] bs, bd;
        logic [15:0] cnt;
        int          seen;
        vecs[0] = '{16'd3,     8'hA4, 16'd3, 1'b0};
        vecs[1] = '{16'd8,     8'hFF, 16'd8, 1'b0};
        vecs[2] = '{16'd20,    8'hFF, 16'd8, 1'b1};
        vecs[3] = '{16'd0,     8'h00, 16'd0, 1'b0};
        vecs[4] = '{16'd1,     8'h80, 16'd1, 1'b0};
        vecs[5] = '{16'd7,     8'hFE, 16'd7, 1'b0};
        vecs[6] = '{16'd5,     8'hDA, 16'd5, 1'b0};
        vecs[7] = '{16'd6,     8'hEE, 16'd6, 1'b0};
        vecs[8] = '{16'd9,     8'hFF, 16'd8, 1'b1};
        vecs[9] = '{16'd65535, 8'hFF, 16'd8, 1'b1};
        bus.in_valid = 1'b0;
        bus.in_count = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(bus.in_ready), 0);
        chk("rst_outputs", 32'({bus.spike, bus.frame_active, bus.frame_done, bus.clipped}), 0);
        chk("rst_emitted", 32'(bus.emitted_count), 0);
        rst = 1'b0;
        #1;
        chk("ready_after_rst", 32'(bus.in_ready), 1);
        @(negedge clk);
        for (int i = 0; i < 10; i++) check_frame(vecs[i]);
        // Reset mid-frame: accept 5, reset sampled at E4
        wait_ready();
        bus.in_valid = 1'b1;
        bus.in_count = 16'd5;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_spike", 32'(bus.spike), 0);
        chk("abort_emitted", 32'(bus.emitted_count), 0);
        chk("abort_active", 32'(bus.frame_active), 0);
        chk("abort_ready_in_rst", 32'(bus.in_ready), 0);
        rst = 1'b0;
        #1;
        chk("abort_ready_after", 32'(bus.in_ready), 1);
        seen = 0;
        for (int c = 0; c < 2 * W; c++) begin
            @(negedge clk);
            seen += int'(bus.frame_done) + int'(bus.spike);
        end
        chk("abort_no_done_or_spike", 32'(seen), 0);
        check_frame('{16'd2, 8'h88, 16'd2, 1'b0});
        // Back-to-back frames with in_valid held high
        wait_ready();
        bus.in_valid = 1'b1;
        bus.in_count = 16'd4;
        @(posedge clk);
        for (int c = 0; c < 18; c++) begin
            @(negedge clk);
            bs[c] = bus.spike;
            bd[c] = bus.frame_done;
            if (c == 9) bus.in_valid = 1'b0;
        end
        chk("b2b_spike", 32'(bs), 32'h2A954);
        chk("b2b_done", 32'(bd), 32'h20100);
        chk("b2b_emitted", 32'(bus.emitted_count), 4);
        // Random counts: re-integrated spike total must equal min(count, W) and emitted_count
        for (int f = 0; f < 200; f++) begin
            cnt = (f % 3 == 0) ? 16'($urandom) : 16'($urandom_range(0, 10));
            run_frame(cnt, sm, dm, rm, am);
            chk($sformatf("rand_total[%0d]", cnt), 32'($countones(sm)), (cnt > 16'(W)) ? W : 32'(cnt));
            chk($sformatf("rand_emitted[%0d]", cnt), 32'(bus.emitted_count), 32'($countones(sm)));
        end
        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end
endmodule
